// File: rtl/tof_mem_pkg.sv
// ToF frame memory reader: shared FSM encodings and defaults.
// Optional header word per frame is enabled with the TOF_RD_HEADER_EN macro.
package tof_mem_pkg;

    localparam int DEF_NUM_SENSORS     = 8;
    localparam int DEF_WORDS_PER_FRAME = 16;

    localparam logic [7:0] TOF_HDR_MAGIC = 8'hA5;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_HOLD  = 2'd3;

endpackage

// File: rtl/tof_rr_pick.sv
// Round-robin pick: first set bit of fresh at or after ptr, wrapping.
// Purely combinational; any_fresh is low when no slot is pending.
module tof_rr_pick #(
    parameter int NUM_SENSORS = 8,
    parameter int IDX_W       = $clog2(NUM_SENSORS)
) (
    input  logic [NUM_SENSORS-1:0] fresh,
    input  logic [IDX_W-1:0]       ptr,
    output logic [IDX_W-1:0]       pick,
    output logic                   any_fresh
);

    // Walk offsets from far to near so the nearest set slot wins.
    always_comb begin
        pick      = '0;
        any_fresh = 1'b0;
        for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
            int j;
            j = (int'(ptr) + i) % NUM_SENSORS;
            if (fresh[j]) begin
                pick      = IDX_W'(j);
                any_fresh = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tof_mem_reader.sv
// Streams fresh ToF frames from BRAM to the host link, round-robin by slot.
// Define TOF_RD_HEADER_EN to prefix each frame with a magic/seq/slot header.
module tof_mem_reader
    import tof_mem_pkg::*;
#(
    parameter int NUM_SENSORS     = DEF_NUM_SENSORS,
    parameter int WORDS_PER_FRAME = DEF_WORDS_PER_FRAME,
    parameter int DATA_W          = 32,
    parameter int RD_LATENCY      = 2,
    localparam int IDX_W          = $clog2(NUM_SENSORS),
    localparam int WORD_W         = $clog2(WORDS_PER_FRAME)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_wea,
    input  logic [IDX_W-1:0]        wr_index,
    output logic                    mem_en,
    output logic [IDX_W+WORD_W-1:0] mem_addr,
    input  logic [DATA_W-1:0]       mem_dout,
    output logic [DATA_W-1:0]       out_data,
    output logic [IDX_W-1:0]        out_index,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun
);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       slot_q, slot_d;
    logic [WORD_W-1:0]      word_q, word_d;
    logic [1:0]             lat_q, lat_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [NUM_SENSORS-1:0] fresh_q, fresh_d;
    logic [NUM_SENSORS-1:0] set_v, clr_v;
    logic                   wea_q;
    logic                   overrun_q, overrun_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [IDX_W-1:0]       index_q, index_d;
    logic                   last_q, last_d;
    logic [IDX_W-1:0]       pick;
    logic                   any_fresh;
    logic                   wea_rise;
`ifdef TOF_RD_HEADER_EN
    logic                   hdr_q, hdr_d;
    logic [7:0]             seq_q, seq_d;
`endif

    tof_rr_pick #(
        .NUM_SENSORS(NUM_SENSORS),
        .IDX_W      (IDX_W)
    ) u_pick (
        .fresh    (fresh_q),
        .ptr      (ptr_q),
        .pick     (pick),
        .any_fresh(any_fresh)
    );

    assign wea_rise  = wr_wea && !wea_q;
    assign mem_en    = (state_q == ST_ISSUE);
    assign mem_addr  = {slot_q, word_q};
    assign out_valid = (state_q == ST_HOLD);
    assign out_data  = data_q;
    assign out_index = index_q;
    assign out_last  = last_q;
    assign overrun   = overrun_q;

    // Fresh bitmap: writer rising edge sets, pick clears, set wins.
    always_comb begin
        set_v = '0;
        if (wea_rise) set_v[wr_index] = 1'b1;
        fresh_d   = (fresh_q & ~clr_v) | set_v;
        overrun_d = overrun_q | (wea_rise && fresh_q[wr_index]);
    end

    // Reader FSM: pick slot, one read in flight, hold word until accepted.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        word_d  = word_q;
        lat_d   = lat_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        index_d = index_q;
        last_d  = last_q;
        clr_v   = '0;
`ifdef TOF_RD_HEADER_EN
        hdr_d   = hdr_q;
        seq_d   = seq_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_fresh) begin
                    slot_d      = pick;
                    word_d      = '0;
                    clr_v[pick] = 1'b1;
`ifdef TOF_RD_HEADER_EN
                    data_d  = {TOF_HDR_MAGIC, seq_q,
                               {(DATA_W-16-IDX_W){1'b0}}, pick};
                    index_d = pick;
                    last_d  = 1'b0;
                    hdr_d   = 1'b1;
                    state_d = ST_HOLD;
`else
                    state_d = ST_ISSUE;
`endif
                end
            end
            ST_ISSUE: begin
                lat_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_q == 2'(RD_LATENCY - 1)) begin
                    data_d  = mem_dout;
                    index_d = slot_q;
                    last_d  = (word_q == WORD_W'(WORDS_PER_FRAME - 1));
                    state_d = ST_HOLD;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            default: begin
                if (out_ready) begin
`ifdef TOF_RD_HEADER_EN
                    if (hdr_q) begin
                        hdr_d   = 1'b0;
                        state_d = ST_ISSUE;
                    end else
`endif
                    if (word_q == WORD_W'(WORDS_PER_FRAME - 1)) begin
                        ptr_d   = (slot_q == IDX_W'(NUM_SENSORS - 1)) ?
                                  '0 : slot_q + IDX_W'(1);
                        state_d = ST_IDLE;
`ifdef TOF_RD_HEADER_EN
                        seq_d   = seq_q + 8'd1;
`endif
                    end else begin
                        word_d  = word_q + WORD_W'(1);
                        state_d = ST_ISSUE;
                    end
                end
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            slot_q    <= '0;
            word_q    <= '0;
            lat_q     <= '0;
            ptr_q     <= '0;
            fresh_q   <= '0;
            wea_q     <= 1'b0;
            overrun_q <= 1'b0;
            data_q    <= '0;
            index_q   <= '0;
            last_q    <= 1'b0;
`ifdef TOF_RD_HEADER_EN
            hdr_q     <= 1'b0;
            seq_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            word_q    <= word_d;
            lat_q     <= lat_d;
            ptr_q     <= ptr_d;
            fresh_q   <= fresh_d;
            wea_q     <= wr_wea;
            overrun_q <= overrun_d;
            data_q    <= data_d;
            index_q   <= index_d;
            last_q    <= last_d;
`ifdef TOF_RD_HEADER_EN
            hdr_q     <= hdr_d;
            seq_q     <= seq_d;
`endif
        end
    end

endmodule
